// File: rtl/signed_divider.sv
`timescale 1ns/1ps
// signed_divider
//   Sequential signed divider, radix-2 restoring, one quotient bit per cycle.
//   Divides a 2W-bit signed dividend (typically a multiplier product) by a W-bit
//   signed divisor. It uses the same input_ready / output_valid handshake as the
//   multiplier, so a product can be checked or undone in the same datapath.
//   Fixed latency: outputs register 2W+1 edges after the accept edge.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   input_ready  start strobe, sampled only while idle
//   dividend     2W-bit signed dividend
//   divisor      W-bit signed divisor
//   busy         high from the accept edge until output_valid drops
//   output_valid one-cycle pulse; quot/rem/ovf valid from this cycle on
//   quot         W-bit signed quotient, truncated toward zero (saturated on ovf)
//   rem          W-bit signed remainder, sign follows the dividend (0 on ovf)
//   ovf          divide-by-zero or quotient outside the W-bit signed range
module signed_divider #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_ready,
    input  logic signed [2*W-1:0] dividend,
    input  logic signed [W-1:0]   divisor,
    output logic                  busy,
    output logic                  output_valid,
    output logic signed [W-1:0]   quot,
    output logic signed [W-1:0]   rem,
    output logic                  ovf
);

    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0]  LAST_STEP = CW'(2*W-1);
    // 2^(W-1): largest quotient magnitude representable when the result is negative
    localparam logic [2*W-1:0] NEG_LIM   = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic signed [W-1:0] sat_q(input logic neg);
        return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    // Positive results may reach 2^(W-1)-1, negative ones 2^(W-1).
    function automatic logic q_range_ovf(input logic [2*W-1:0] mag, input logic neg);
        return neg ? (mag > NEG_LIM) : (mag >= NEG_LIM);
    endfunction

    // Negating a zero magnitude yields zero, so results are never "negative zero".
    function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sa;      // dividend sign
    logic            r_sb;      // divisor sign
    logic [2*W-1:0]  r_dvd;     // |dividend| shifting out, quotient bits shifting in
    logic [W:0]      r_dsr;     // |divisor|, one extra bit so |-2^(W-1)| fits
    logic [W:0]      r_part;    // partial remainder

    logic [2*W-1:0]  w_dvd_mag;
    logic [W:0]      w_dsr_mag;
    logic [W+1:0]    w_shift;
    logic            w_ge;
    logic            w_qneg;
    logic            w_dz;
    logic            w_rovf;

    assign w_dvd_mag = dividend[2*W-1] ? (~dividend + 1'b1) : dividend;
    assign w_dsr_mag = divisor[W-1] ? (~{divisor[W-1], divisor} + 1'b1) : {1'b0, divisor};

    assign w_shift = {r_part, r_dvd[2*W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dsr});
    assign w_qneg  = r_sa ^ r_sb;
    assign w_dz    = (r_dsr == '0);
    assign w_rovf  = q_range_ovf(r_dvd, w_qneg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_dvd        <= '0;
            r_dsr        <= '0;
            r_part       <= '0;
            busy         <= 1'b0;
            output_valid <= 1'b0;
            quot         <= '0;
            rem          <= '0;
            ovf          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (input_ready) begin
                        r_sa    <= dividend[2*W-1];
                        r_sb    <= divisor[W-1];
                        r_dvd   <= w_dvd_mag;
                        r_dsr   <= w_dsr_mag;
                        r_part  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // With a zero divisor the compare always passes; the result is
                    // discarded in FIX, so the partial remainder may wrap harmlessly.
                    r_dvd  <= {r_dvd[2*W-2:0], w_ge};
                    r_part <= w_ge ? (w_shift[W:0] - r_dsr) : w_shift[W:0];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (w_dz) begin
                        ovf  <= 1'b1;
                        quot <= sat_q(r_sa);
                        rem  <= '0;
                    end else if (w_rovf) begin
                        ovf  <= 1'b1;
                        quot <= sat_q(w_qneg);
                        rem  <= '0;
                    end else begin
                        ovf  <= 1'b0;
                        quot <= apply_sign(r_dvd[W-1:0], w_qneg);
                        rem  <= apply_sign(r_part[W-1:0], r_sa);
                    end
                    output_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    output_valid <= 1'b0;
                    busy         <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
`timescale 1ns/1ps
// Testbench for signed_divider (W=16): table-driven vectors, corner sequences and a
// random sweep, all results compared through an expectation queue.
module tb_signed_divider;

    localparam int W   = 16;
    localparam int LAT = 2*W + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  input_ready = 1'b0;
    logic signed [2*W-1:0] dividend = '0;
    logic signed [W-1:0]   divisor = '0;
    logic                  busy;
    logic                  output_valid;
    logic signed [W-1:0]   quot;
    logic signed [W-1:0]   rem;
    logic                  ovf;

    signed_divider #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_ready  (input_ready),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .output_valid (output_valid),
        .quot         (quot),
        .rem          (rem),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [2*W-1:0] a;
        logic signed [W-1:0]   b;
        logic signed [W-1:0]   q;
        logic signed [W-1:0]   r;
        logic                  o;
    } vec_t;

    typedef struct {
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        logic                o;
        int                  t0;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference using 64-bit integer division (truncates toward zero).
    function automatic exp_t model(input logic signed [2*W-1:0] a, input logic signed [W-1:0] b);
        exp_t   e;
        longint la = a;
        longint lb = b;
        longint lq;
        longint lr;
        e.t0 = 0;
        if (lb == 0) begin
            e.o = 1'b1;
            e.r = '0;
            e.q = (la >= 0) ? 16'sh7fff : 16'sh8000;
        end else begin
            lq = la / lb;
            lr = la % lb;
            if (lq > 32767) begin
                e.o = 1'b1; e.q = 16'sh7fff; e.r = '0;
            end else if (lq < -32768) begin
                e.o = 1'b1; e.q = 16'sh8000; e.r = '0;
            end else begin
                e.o = 1'b0; e.q = 16'(lq); e.r = 16'(lr);
            end
        end
        return e;
    endfunction

    // Monitor: sample 1 time unit after each rising edge, pop and compare on output_valid.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        if (output_valid) begin
            if (prev_ov) chk("valid_pulse_width", 2, 1);
            if (sbq.size() == 0) begin
                chk("unexpected_output_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("quot", quot, e.q);
                chk("rem", rem, e.r);
                chk("ovf", ovf, e.o);
                chk("latency", cyc - e.t0, LAT);
            end
        end
        prev_ov = output_valid;
    end

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_op(input logic signed [2*W-1:0] a, input logic signed [W-1:0] b,
                         input exp_t e_in);
        exp_t e;
        @(negedge clk);
        wait_idle();
        dividend    = a;
        divisor     = b;
        input_ready = 1'b1;
        e           = e_in;
        e.t0        = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        input_ready = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((sbq.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0 || busy) chk("drain_timeout", 1, 0);
    endtask

    vec_t vt[16];

    initial begin
        exp_t e;
        logic signed [2*W-1:0] ra;
        logic signed [W-1:0]   rb;
        longint                lp;

        vt[0]  = '{32'sd65535,        16'sd21845,  16'sd3,      16'sd0,  1'b0};
        vt[1]  = '{32'sd715827882,    -16'sd32767, -16'sd21846, 16'sd0,  1'b0};
        vt[2]  = '{-32'sd7,           16'sd2,      -16'sd3,     -16'sd1, 1'b0};
        vt[3]  = '{32'sd7,            -16'sd2,     -16'sd3,     16'sd1,  1'b0};
        vt[4]  = '{32'sd100,          16'sd0,      16'sd32767,  16'sd0,  1'b1};
        vt[5]  = '{-32'sd100,         16'sd0,      16'sh8000,   16'sd0,  1'b1};
        vt[6]  = '{32'sh80000000,     -16'sd1,     16'sd32767,  16'sd0,  1'b1};
        vt[7]  = '{32'sd1073741824,   16'sh8000,   16'sh8000,   16'sd0,  1'b0};
        vt[8]  = '{32'sh80000000,     16'sd1,      16'sh8000,   16'sd0,  1'b1};
        vt[9]  = '{32'sd0,            16'sd5,      16'sd0,      16'sd0,  1'b0};
        vt[10] = '{-32'sd5,           16'sd7,      16'sd0,      -16'sd5, 1'b0};
        vt[11] = '{32'sd1073676289,   16'sd32767,  16'sd32767,  16'sd0,  1'b0};
        vt[12] = '{32'sd1073709056,   16'sd32767,  16'sd32767,  16'sd0,  1'b1};
        vt[13] = '{-32'sd1073741824,  16'sd32767,  16'sh8000,   16'sd0,  1'b1};
        vt[14] = '{-32'sd1073741824,  16'sh8000,   16'sd32767,  16'sd0,  1'b1};
        vt[15] = '{32'sd0,            16'sd0,      16'sd32767,  16'sd0,  1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_output_valid", output_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Table-driven vectors, issued back to back as soon as the divider is idle
        for (int i = 0; i < 16; i++) begin
            e.q = vt[i].q; e.r = vt[i].r; e.o = vt[i].o; e.t0 = 0;
            do_op(vt[i].a, vt[i].b, e);
        end
        wait_drain();

        // input_ready held high with operands changing every cycle:
        // accepts occur only at idle edges, every 2W+3 cycles
        @(negedge clk);
        wait_idle();
        input_ready = 1'b1;
        for (int k = 0; k < 3*(2*W+3); k++) begin
            dividend = $signed($urandom);
            divisor  = $signed(16'($urandom));
            if (k % (2*W+3) == 0) begin
                e    = model(dividend, divisor);
                e.t0 = cyc + 1;
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        input_ready = 1'b0;
        wait_drain();

        // Reset during CALC aborts; no stale output_valid, outputs cleared
        e = model(32'sd1000, 16'sd7);
        do_op(32'sd1000, 16'sd7, e);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_output_valid", output_valid, 0);
        chk("abort_quot", quot, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        e.q = 16'sd2; e.r = 16'sd0; e.o = 1'b0; e.t0 = 0;
        do_op(32'sd6, 16'sd3, e);
        wait_drain();
        repeat (5) @(negedge clk);

        // Random sweep with corner operands mixed in
        for (int n = 0; n < 1000; n++) begin
            case (n % 6)
                0: ra = 32'sh80000000;
                1: begin
                    lp = longint'($signed(16'($urandom))) * longint'($signed(16'($urandom)))
                         + longint'($urandom_range(0, 200)) - 100;
                    ra = 32'(lp);
                end
                default: ra = $signed($urandom);
            endcase
            case (n % 7)
                0: rb = 16'sh8000;
                1: rb = -16'sd1;
                2: rb = 16'sd0;
                default: rb = $signed(16'($urandom));
            endcase
            do_op(ra, rb, model(ra, rb));
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
